// File: rtl/cpu_io_pkg.sv
// ============================================================================
// Module      : cpu_io_pkg
// Description : Shared serializer state encoding and UART framing constants
//               for the CPU output path.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cpu_io_pkg;

    // Serializer states; explicit two-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 8N1 framing.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Number of UART bytes needed to carry one CPU word.
    function automatic int bytes_per_word(input int word_size);
        return word_size / DATA_BITS;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_output_uart_tx_if.sv
// ============================================================================
// Module      : cpu_output_uart_tx_if
// Description : CPU output strobe/data plus UART line and status flags.
//               master = CPU side, slave = UART sink.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface cpu_output_uart_tx_if #(
    parameter int WORD_SIZE = 32
);
    logic                 output_en;
    logic [WORD_SIZE-1:0] data_out;
    logic                 tx;
    logic                 full;
    logic                 busy;
    logic                 overflow;

    modport master (
        output output_en, data_out,
        input  tx, full, busy, overflow
    );

    modport slave (
        input  output_en, data_out,
        output tx, full, busy, overflow
    );
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered count/full/empty.
//               DEPTH must be a power of two so pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);
    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_lvl_w = $clog2(DEPTH) + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_lvl_w-1:0] c_lvl_max = c_lvl_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_lvl_w-1:0] r_count;
    logic               r_full;
    logic               r_empty;

    logic               w_do_push;
    logic               w_do_pop;
    logic [c_lvl_w-1:0] w_count_next;

    // Requests against a full/empty FIFO are ignored.
    assign w_do_push    = push && !r_full;
    assign w_do_pop     = pop && !r_empty;
    assign w_count_next = r_count + {{(c_lvl_w-1){1'b0}}, w_do_push}
                                  - {{(c_lvl_w-1){1'b0}}, w_do_pop};

    // Storage array; no reset needed, contents are only read when valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, level and status flags registered from the next level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_lvl_max);
            r_empty <= (w_count_next == '0);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/cpu_output_uart_tx.sv
// ============================================================================
// Module      : cpu_output_uart_tx
// Description : Captures CPU output words into a FIFO and sends each word as
//               WORD_SIZE/8 UART 8N1 bytes, least-significant byte first.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_output_uart_tx
    import cpu_io_pkg::*;
#(
    parameter int WORD_SIZE    = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input wire logic            clk,
    input wire logic            rst,
    cpu_output_uart_tx_if.slave bus
);
    localparam int c_bpw    = bytes_per_word(WORD_SIZE);
    localparam int c_cnt_w  = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam int c_bit_w  = $clog2(DATA_BITS);
    localparam int c_byte_w = (c_bpw > 1) ? $clog2(c_bpw) : 1;
    localparam int c_lvl_w  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]  c_stop_last = c_cnt_w'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(DATA_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_bit_one   = c_bit_w'(1);
    localparam logic [c_byte_w-1:0] c_byte_last = c_byte_w'(c_bpw - 1);
    localparam logic [c_byte_w-1:0] c_byte_one  = c_byte_w'(1);

    uart_state_t          r_state;
    logic                 r_tx;
    logic                 r_busy;
    logic                 r_overflow;
    logic [c_cnt_w-1:0]   r_clk_cnt;
    logic [c_bit_w-1:0]   r_bit_cnt;
    logic [c_byte_w-1:0]  r_byte_idx;
    logic [WORD_SIZE-1:0] r_shift;

    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic [WORD_SIZE-1:0] w_dout;
    logic [c_lvl_w-1:0]   w_count;
    logic [c_lvl_w-1:0]   w_count_next;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_bit_done;
    logic                 w_stop_done;
    logic                 w_frame_done;
    logic                 w_active_next;

    // Registered full gates the push, so a word offered while full is
    // dropped even if a pop frees a slot on the same edge.
    assign w_push = bus.output_en && !w_full;
    assign w_drop = bus.output_en && w_full;
    assign w_pop  = (r_state == IDLE) && !w_empty;

    sync_fifo #(
        .WIDTH (WORD_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.data_out),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_bit_done    = (r_clk_cnt == c_bit_last);
    assign w_stop_done   = (r_clk_cnt == c_stop_last);
    assign w_frame_done  = (r_state == STOP) && w_stop_done && (r_byte_idx == c_byte_last);
    assign w_active_next = ((r_state != IDLE) && !w_frame_done) || w_pop;
    assign w_count_next  = w_count + {{(c_lvl_w-1){1'b0}}, w_push}
                                   - {{(c_lvl_w-1){1'b0}}, w_pop};

    // Serializer FSM; tx is loaded with the value for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tx       <= 1'b1;
            r_clk_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx      <= 1'b1;
                    r_clk_cnt <= '0;
                    if (w_pop) begin
                        r_shift    <= w_dout;
                        r_byte_idx <= '0;
                        r_bit_cnt  <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        r_shift   <= r_shift >> 1;
                        if (r_bit_cnt == c_data_last) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_bit_one;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                STOP: begin
                    if (w_stop_done) begin
                        r_clk_cnt <= '0;
                        if (r_byte_idx == c_byte_last) begin
                            r_state <= IDLE;
                        end else begin
                            // Next byte continues from the same shift register.
                            r_byte_idx <= r_byte_idx + c_byte_one;
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_cnt_one;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Status flags: busy from next-state level/FSM, overflow sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_busy     <= (w_count_next != '0) || w_active_next;
            r_overflow <= r_overflow || w_drop;
        end
    end

    assign bus.tx       = r_tx;
    assign bus.full     = w_full;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_overflow;

endmodule

`default_nettype wire
